comma_sync_fsm: RTL and testbench

Parametrised comma detection and symbol-lock FSM for the PHY receive path. It sits between the deserialiser bit stream and the 8b/10b decoder. It shifts serial bits into a SYM_W-bit window and acquires lock after a programmable run of aligned commas. Once locked it emits framed symbols with valid and comma pulses, and drops lock on repeated misaligned commas.

---
 rtl/comma_sync_pkg.sv | 27 ++
 rtl/comma_sync_window.sv | 31 +++
 rtl/comma_sync_fsm.sv | 183 ++++++++++++++++++
 tb/tb_comma_sync_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comma_sync_pkg.sv
// Shared types and constants for the comma detection / symbol-lock block.
package comma_sync_pkg;

  // Default symbol width (8b/10b code groups)
  localparam int SYM_W_DEF = 10;

  // K28.5 comma code groups, both running disparities
  localparam logic [9:0] K28_5_P = 10'h0FA;
  localparam logic [9:0] K28_5_N = 10'h305;

  // Lock FSM states; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ALIGN  = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Required comma count: zero behaves as one, large requests saturate
  function automatic int clamp_count(input int req, input int max_v);
    int r;
    r = req;
    if (r > max_v) r = max_v;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/comma_sync_window.sv
// Serial-to-parallel window with K28.5 comma comparison.
module comma_sync_window
  import comma_sync_pkg::*;
#(
  parameter int               SYM_W   = SYM_W_DEF,
  parameter logic [SYM_W-1:0] COMMA_P = K28_5_P,
  parameter logic [SYM_W-1:0] COMMA_N = K28_5_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic             bit_in,
  output logic [SYM_W-1:0] sr,
  output logic             match
);

  logic [SYM_W-1:0] sr_reg;

  // Shift each qualified bit into the window LSB; newest bit is the symbol LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (bit_vld) begin
      sr_reg <= {sr_reg[SYM_W-2:0], bit_in};
    end
  end

  assign sr    = sr_reg;
  assign match = (sr_reg == COMMA_P) || (sr_reg == COMMA_N);

endmodule

// File: rtl/comma_sync_fsm.sv
// Comma detection and symbol-lock FSM: acquires lock after n aligned commas,
// frames symbols while locked and drops lock on repeated misaligned commas.
module comma_sync_fsm
  import comma_sync_pkg::*;
#(
  parameter int               SYM_W      = SYM_W_DEF,
  parameter logic [SYM_W-1:0] COMMA_P    = K28_5_P,
  parameter logic [SYM_W-1:0] COMMA_N    = K28_5_N,
  parameter int               MAX_COMMA  = 8,
  parameter int               LOS_THRESH = 4,
  localparam int              CW         = $clog2(MAX_COMMA + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic [CW-1:0]    comma_num,
  output logic [SYM_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             comma_pulse,
  output logic             locked,
  output logic             los,
  output logic [1:0]       state
);

  localparam int PW = $clog2(SYM_W);
  localparam int LW = $clog2(LOS_THRESH + 1);

  logic [SYM_W-1:0] sr;
  logic             match;

  state_t           state_reg, state_next;
  logic [PW-1:0]    ph_reg, ph_next;
  logic [CW-1:0]    seen_reg, seen_next;
  logic [CW-1:0]    n_reg, n_next;
  logic [LW-1:0]    los_cnt_reg, los_cnt_next;
  logic [SYM_W-1:0] rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             comma_reg, comma_next;
  logic             locked_reg, locked_next;
  logic             los_reg, los_next;

  logic             boundary;
  logic [CW-1:0]    n_clamped;
  logic [CW-1:0]    seen_inc;
  logic [LW-1:0]    los_inc;

  comma_sync_window #(
    .SYM_W   (SYM_W),
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .bit_vld (bit_vld),
    .bit_in  (bit_in),
    .sr      (sr),
    .match   (match)
  );

  assign boundary  = (ph_reg == PW'(SYM_W - 1));
  assign n_clamped = CW'(clamp_count(int'(comma_num), MAX_COMMA));
  assign seen_inc  = seen_reg + CW'(1);
  assign los_inc   = los_cnt_reg + LW'(1);

  // Next-state, counters and output pulses; everything holds when bit_vld is low
  always_comb begin
    state_next    = state_reg;
    ph_next       = ph_reg;
    seen_next     = seen_reg;
    n_next        = n_reg;
    los_cnt_next  = los_cnt_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    comma_next    = 1'b0;
    los_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bit_vld) begin
          ph_next = '0;
          if (match) begin
            // comma_num is sampled only here; later changes wait for the next exit
            n_next       = n_clamped;
            los_cnt_next = '0;
            if (n_clamped == CW'(1)) begin
              state_next = ST_LOCKED;
            end else begin
              state_next = ST_ALIGN;
              seen_next  = CW'(1);
            end
          end
        end
      end

      ST_ALIGN: begin
        if (bit_vld) begin
          ph_next = boundary ? '0 : ph_reg + PW'(1);
          if (boundary) begin
            if (match) begin
              if (seen_inc == n_reg) begin
                state_next = ST_LOCKED;
                seen_next  = '0;
              end else begin
                seen_next = seen_inc;
              end
            end else begin
              state_next = ST_IDLE;
              seen_next  = '0;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (bit_vld) begin
          ph_next = boundary ? '0 : ph_reg + PW'(1);
          if (boundary) begin
            rx_data_next  = sr;
            rx_valid_next = 1'b1;
            if (match) begin
              comma_next   = 1'b1;
              los_cnt_next = '0;
            end
          end else if (match) begin
            // A comma off the symbol grid means our framing is suspect
            if (los_inc == LW'(LOS_THRESH)) begin
              state_next   = ST_IDLE;
              los_next     = 1'b1;
              los_cnt_next = '0;
            end else begin
              los_cnt_next = los_inc;
            end
          end
        end
      end

      default: begin
        state_next   = ST_IDLE;
        ph_next      = '0;
        seen_next    = '0;
        los_cnt_next = '0;
      end
    endcase

    locked_next = (state_next == ST_LOCKED);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ph_reg       <= '0;
      seen_reg     <= '0;
      n_reg        <= CW'(1);
      los_cnt_reg  <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      comma_reg    <= 1'b0;
      locked_reg   <= 1'b0;
      los_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ph_reg       <= ph_next;
      seen_reg     <= seen_next;
      n_reg        <= n_next;
      los_cnt_reg  <= los_cnt_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      comma_reg    <= comma_next;
      locked_reg   <= locked_next;
      los_reg      <= los_next;
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign comma_pulse = comma_reg;
  assign locked      = locked_reg;
  assign los         = los_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_comma_sync_fsm.sv
// Directed self-checking bench for comma_sync_fsm.
module tb_comma_sync_fsm;

  localparam int LOGN = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_vld;
  logic       bit_in;
  logic [3:0] comma_num;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       comma_pulse;
  logic       locked;
  logic       los;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-call log of the outputs observed just after each clock edge
  logic [9:0] lg_data   [LOGN];
  logic       lg_valid  [LOGN];
  logic       lg_comma  [LOGN];
  logic       lg_locked [LOGN];
  logic       lg_los    [LOGN];
  logic [1:0] lg_state  [LOGN];
  logic       lg_vin    [LOGN];

  comma_sync_fsm #(
    .MAX_COMMA  (8),
    .LOS_THRESH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_vld     (bit_vld),
    .bit_in      (bit_in),
    .comma_num   (comma_num),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .comma_pulse (comma_pulse),
    .locked      (locked),
    .los         (los),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic step(input logic b, input logic v);
    bit_in  = b;
    bit_vld = v;
    @(posedge clk);
    #1;
    if (cyc >= LOGN) begin
      $display("FAIL log_overflow: got=%0d want<%0d", cyc, LOGN);
      $fatal(1, "log overflow");
    end
    lg_data[cyc]   = rx_data;
    lg_valid[cyc]  = rx_valid;
    lg_comma[cyc]  = comma_pulse;
    lg_locked[cyc] = locked;
    lg_los[cyc]    = los;
    lg_state[cyc]  = state;
    lg_vin[cyc]    = v;
    cyc++;
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) step(s[i], 1'b1);
  endtask

  task automatic send_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    comma_num = 4'd1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL reset_rx_data: got=%h want=000", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got=%b want=0", rx_valid); end
    total++; if (comma_pulse !== 1'b0) begin bad++; $display("FAIL reset_comma: got=%b want=0", comma_pulse); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got=%b want=0", locked); end
    total++; if (los !== 1'b0) begin bad++; $display("FAIL reset_los: got=%b want=0", los); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got=%b want=00", state); end
    $display("test_reset: done");
  endtask

  task automatic test_lock1();
    int t;
    logic [9:0] syms [4];
    syms[0] = 10'h155; syms[1] = 10'h1B6; syms[2] = 10'h249; syms[3] = 10'h2AA;
    do_reset();
    comma_num = 4'd1;
    send_sym(10'h0FA);
    t = cyc - 1;
    for (int k = 0; k < 4; k++) send_sym(syms[k]);
    step(1'b0, 1'b1);
    total++; if (lg_locked[t] !== 1'b0) begin bad++; $display("FAIL lock1_pre: got=%b want=0", lg_locked[t]); end
    total++; if (lg_locked[t+1] !== 1'b1) begin bad++; $display("FAIL lock1_rise: got=%b want=1", lg_locked[t+1]); end
    total++; if (lg_state[t+1] !== 2'b10) begin bad++; $display("FAIL lock1_state: got=%b want=10", lg_state[t+1]); end
    total++; if (lg_valid[t+10] !== 1'b0) begin bad++; $display("FAIL lock1_early_valid: got=%b want=0", lg_valid[t+10]); end
    for (int k = 0; k < 4; k++) begin
      total++; if (lg_valid[t+11+10*k] !== 1'b1 || lg_data[t+11+10*k] !== syms[k] || lg_comma[t+11+10*k] !== 1'b0) begin
        bad++; $display("FAIL lock1_sym%0d: got valid=%b data=%h comma=%b want valid=1 data=%h comma=0",
                        k, lg_valid[t+11+10*k], lg_data[t+11+10*k], lg_comma[t+11+10*k], syms[k]);
      end
    end
    total++; if (lg_valid[t+12] !== 1'b0) begin bad++; $display("FAIL lock1_pulse_width: got=%b want=0", lg_valid[t+12]); end
    $display("test_lock1: done");
  endtask

  task automatic test_lock4();
    int t;
    do_reset();
    comma_num = 4'd4;
    send_sym(10'h0FA);
    t = cyc - 1;
    send_sym(10'h305); send_sym(10'h0FA); send_sym(10'h305);
    send_sym(10'h155);
    step(1'b0, 1'b1);
    total++; if (lg_state[t+1] !== 2'b01) begin bad++; $display("FAIL lock4_align: got=%b want=01", lg_state[t+1]); end
    total++; if (lg_locked[t+30] !== 1'b0) begin bad++; $display("FAIL lock4_pre: got=%b want=0", lg_locked[t+30]); end
    total++; if (lg_locked[t+31] !== 1'b1 || lg_state[t+31] !== 2'b10) begin
      bad++; $display("FAIL lock4_rise: got locked=%b state=%b want locked=1 state=10", lg_locked[t+31], lg_state[t+31]);
    end
    total++; if (lg_valid[t+41] !== 1'b1 || lg_data[t+41] !== 10'h155) begin
      bad++; $display("FAIL lock4_first_valid: got valid=%b data=%h want valid=1 data=155", lg_valid[t+41], lg_data[t+41]);
    end
    // Broken run: a data symbol on the third boundary sends the FSM back to IDLE
    do_reset();
    comma_num = 4'd4;
    send_sym(10'h0FA);
    t = cyc - 1;
    send_sym(10'h305); send_sym(10'h0FA); send_sym(10'h155);
    step(1'b0, 1'b1);
    total++; if (lg_state[t+30] !== 2'b01) begin bad++; $display("FAIL lock4_break_pre: got=%b want=01", lg_state[t+30]); end
    total++; if (lg_state[t+31] !== 2'b00 || lg_locked[t+31] !== 1'b0) begin
      bad++; $display("FAIL lock4_break: got state=%b locked=%b want state=00 locked=0", lg_state[t+31], lg_locked[t+31]);
    end
    $display("test_lock4: done");
  endtask

  task automatic test_los();
    int t;
    int e;
    int a;
    int nlos;
    do_reset();
    comma_num = 4'd1;
    send_sym(10'h0FA);
    t = cyc - 1;
    send_sym(10'h155); send_sym(10'h2AA);
    send_bits(10'h002, 3);
    send_sym(10'h0FA); send_sym(10'h305); send_sym(10'h0FA); send_sym(10'h305);
    e = cyc - 1;
    send_sym(10'h155);
    nlos = 0;
    for (int k = t + 1; k <= e; k++) if (lg_los[k] === 1'b1) nlos++;
    total++; if (nlos !== 0) begin bad++; $display("FAIL los_early: got=%0d pulses want=0", nlos); end
    total++; if (lg_locked[e] !== 1'b1) begin bad++; $display("FAIL los_pre_locked: got=%b want=1", lg_locked[e]); end
    total++; if (lg_los[e+1] !== 1'b1 || lg_locked[e+1] !== 1'b0 || lg_state[e+1] !== 2'b00) begin
      bad++; $display("FAIL los_drop: got los=%b locked=%b state=%b want los=1 locked=0 state=00",
                      lg_los[e+1], lg_locked[e+1], lg_state[e+1]);
    end
    total++; if (lg_los[e+2] !== 1'b0) begin bad++; $display("FAIL los_width: got=%b want=0", lg_los[e+2]); end
    // Aligned comma after three misaligned ones restarts the count
    do_reset();
    comma_num = 4'd1;
    send_sym(10'h0FA);
    t = cyc - 1;
    send_sym(10'h155);
    send_bits(10'h002, 3);
    send_sym(10'h0FA); send_sym(10'h305); send_sym(10'h0FA);
    send_bits(10'h055, 7);
    send_sym(10'h0FA);
    a = cyc - 1;
    send_bits(10'h002, 3);
    send_sym(10'h305); send_sym(10'h0FA); send_sym(10'h305);
    step(1'b0, 1'b1);
    e = cyc - 1;
    send_bits(10'h002, 2);
    send_sym(10'h0FA);
    send_bits(10'h155, 10);
    total++; if (lg_valid[a+1] !== 1'b1 || lg_comma[a+1] !== 1'b1 || lg_data[a+1] !== 10'h0FA) begin
      bad++; $display("FAIL los_aligned_comma: got valid=%b comma=%b data=%h want valid=1 comma=1 data=0fa",
                      lg_valid[a+1], lg_comma[a+1], lg_data[a+1]);
    end
    nlos = 0;
    for (int k = t + 1; k <= e; k++) if (lg_los[k] === 1'b1) nlos++;
    total++; if (nlos !== 0 || lg_locked[e] !== 1'b1) begin
      bad++; $display("FAIL los_cleared: got pulses=%0d locked=%b want pulses=0 locked=1", nlos, lg_locked[e]);
    end
    total++; if (lg_los[e+13] !== 1'b1 || lg_locked[e+13] !== 1'b0) begin
      bad++; $display("FAIL los_after_clear: got los=%b locked=%b want los=1 locked=0", lg_los[e+13], lg_locked[e+13]);
    end
    $display("test_los: done");
  endtask

  task automatic test_bit_vld();
    int t;
    int vcnt;
    int np;
    logic [9:0] s;
    logic [9:0] syms [5];
    syms[0] = 10'h1B6; syms[1] = 10'h249; syms[2] = 10'h36D; syms[3] = 10'h0CB; syms[4] = 10'h2AA;
    do_reset();
    comma_num = 4'd1;
    send_sym(10'h0FA);
    t = cyc - 1;
    for (int j = 0; j < 5; j++) begin
      s = syms[j];
      for (int i = 9; i >= 0; i--) begin
        step(s[i], 1'b1);
        step(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    step(1'b0, 1'b1);
    vcnt = 0;
    np = 0;
    for (int k = t + 1; k < cyc; k++) begin
      if (lg_vin[k] === 1'b1) vcnt++;
      if (lg_valid[k] === 1'b1) begin
        total++;
        if (np >= 5 || lg_vin[k] !== 1'b1 || vcnt != ((np == 0) ? 11 : 10) || lg_data[k] !== syms[np < 5 ? np : 0]) begin
          bad++; $display("FAIL bitvld_pulse%0d: got vld_in=%b spacing=%0d data=%h want vld_in=1 spacing=%0d data=%h",
                          np, lg_vin[k], vcnt, lg_data[k], (np == 0) ? 11 : 10, syms[np < 5 ? np : 0]);
        end
        vcnt = 0;
        np++;
      end
    end
    total++; if (np != 5) begin bad++; $display("FAIL bitvld_count: got=%0d want=5", np); end
    $display("test_bit_vld: done");
  endtask

  task automatic test_comma_num();
    int t;
    logic [9:0] c305;
    c305 = 10'h305;
    // comma_num change during ALIGN is ignored
    do_reset();
    comma_num = 4'd4;
    send_sym(10'h0FA);
    t = cyc - 1;
    step(c305[9], 1'b1);
    comma_num = 4'd1;
    send_bits(c305, 9);
    send_sym(10'h0FA); send_sym(10'h305);
    send_sym(10'h155);
    total++; if (lg_locked[t+1] !== 1'b0 || lg_state[t+1] !== 2'b01) begin
      bad++; $display("FAIL cnum_change_align: got locked=%b state=%b want locked=0 state=01", lg_locked[t+1], lg_state[t+1]);
    end
    total++; if (lg_locked[t+30] !== 1'b0) begin bad++; $display("FAIL cnum_change_pre: got=%b want=0", lg_locked[t+30]); end
    total++; if (lg_locked[t+31] !== 1'b1) begin bad++; $display("FAIL cnum_change_rise: got=%b want=1", lg_locked[t+31]); end
    // comma_num = 0 behaves as 1
    do_reset();
    comma_num = 4'd0;
    send_sym(10'h305);
    t = cyc - 1;
    send_sym(10'h155);
    total++; if (lg_locked[t] !== 1'b0 || lg_locked[t+1] !== 1'b1) begin
      bad++; $display("FAIL cnum_zero: got pre=%b rise=%b want pre=0 rise=1", lg_locked[t], lg_locked[t+1]);
    end
    // comma_num above MAX_COMMA saturates at 8
    do_reset();
    comma_num = 4'd15;
    send_sym(10'h0FA);
    t = cyc - 1;
    for (int k = 0; k < 7; k++) send_sym((k % 2 == 0) ? 10'h305 : 10'h0FA);
    send_sym(10'h155);
    total++; if (lg_locked[t+70] !== 1'b0 || lg_locked[t+71] !== 1'b1) begin
      bad++; $display("FAIL cnum_sat: got pre=%b rise=%b want pre=0 rise=1", lg_locked[t+70], lg_locked[t+71]);
    end
    $display("test_comma_num: done");
  endtask

  task automatic test_rst_mid();
    int t;
    do_reset();
    comma_num = 4'd1;
    send_sym(10'h0FA);
    send_sym(10'h155);
    send_bits(10'h00A, 4);
    total++; if (locked !== 1'b1 || rx_data !== 10'h155) begin
      bad++; $display("FAIL rstmid_pre: got locked=%b data=%h want locked=1 data=155", locked, rx_data);
    end
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    total++; if (rx_data !== 10'h000 || rx_valid !== 1'b0 || comma_pulse !== 1'b0 || locked !== 1'b0 || los !== 1'b0 || state !== 2'b00) begin
      bad++; $display("FAIL rstmid_outputs: got data=%h valid=%b comma=%b locked=%b los=%b state=%b want all 0",
                      rx_data, rx_valid, comma_pulse, locked, los, state);
    end
    send_sym(10'h0FA);
    t = cyc - 1;
    send_sym(10'h2AA);
    step(1'b0, 1'b1);
    total++; if (lg_locked[t] !== 1'b0 || lg_locked[t+1] !== 1'b1) begin
      bad++; $display("FAIL rstmid_relock: got pre=%b rise=%b want pre=0 rise=1", lg_locked[t], lg_locked[t+1]);
    end
    total++; if (lg_valid[t+11] !== 1'b1 || lg_data[t+11] !== 10'h2AA) begin
      bad++; $display("FAIL rstmid_first_valid: got valid=%b data=%h want valid=1 data=2aa", lg_valid[t+11], lg_data[t+11]);
    end
    $display("test_rst_mid: done");
  endtask

  initial begin
    rst       = 1'b1;
    bit_vld   = 1'b0;
    bit_in    = 1'b0;
    comma_num = 4'd1;
    test_reset();
    test_lock1();
    test_lock4();
    test_los();
    test_bit_vld();
    test_comma_num();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
